bus_master: RTL and testbench

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/synth_bus_pkg.sv | 24 ++
 rtl/bus_req_fifo.sv | 62 ++++++
 rtl/bus_master.sv | 124 ++++++++++++
 tb/tb_bus_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_bus_pkg.sv
// Shared definitions for the strobed parallel bus master: widths, RW encodings,
// FSM state type and the queued request record.
package synth_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } bus_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/bus_req_fifo.sv
// Request FIFO for the bus master; full/empty come from registered occupancy,
// so a pop never frees a slot for a push in the same cycle.
module bus_req_fifo
  import synth_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clock,
  input  logic     i_reset,
  input  logic     i_push,
  input  bus_req_t i_data,
  input  logic     i_pop,
  output bus_req_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  bus_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rdPtr];

  // Storage is not reset; only valid entries (tracked by r_count) are ever read.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_master.sv
// Parallel bus master: queues requests and runs each as SETUP/STROBE/HOLD phases
// of HALF_PERIOD cycles, driving BusData only for writes.
module bus_master
  import synth_bus_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddress,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              Busy,
  output logic [ADDR_W-1:0] BusAddress,
  inout  wire  [DATA_W-1:0] BusData,
  output logic              BusReadWrite,
  output logic              BusClock
);

  localparam int CNT_W = $clog2(HALF_PERIOD + 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(HALF_PERIOD - 1);

  bus_state_t        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_wdata;
  logic              r_drive;
  bus_req_t          w_reqIn;
  bus_req_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  assign w_reqIn  = '{write: ReqWrite, address: ReqAddress, data: ReqData};
  assign ReqReady = !w_full;
  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign Busy     = (r_state != IDLE) || !w_empty;
  assign BusData  = r_drive ? r_wdata : {DATA_W{1'bz}};

  bus_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clock (Clock),
    .i_reset (Reset),
    .i_push  (ReqValid),
    .i_data  (w_reqIn),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Each phase reloads r_count to HALF_PERIOD-1 and advances when it reaches zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_wdata      <= '0;
      r_drive      <= 1'b0;
      RspValid     <= 1'b0;
      RspData      <= '0;
      BusAddress   <= '0;
      BusReadWrite <= RW_READ;
      BusClock     <= 1'b0;
    end else begin
      RspValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state      <= SETUP;
            r_count      <= PHASE_LAST;
            BusAddress   <= w_head.address;
            BusReadWrite <= w_head.write;
            r_wdata      <= w_head.data;
            r_drive      <= (w_head.write == RW_WRITE);
            BusClock     <= 1'b0;
          end
        end
        SETUP: begin
          if (r_count == '0) begin
            r_state  <= STROBE;
            r_count  <= PHASE_LAST;
            BusClock <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        STROBE: begin
          if (r_count == '0) begin
            r_state  <= HOLD;
            r_count  <= PHASE_LAST;
            BusClock <= 1'b0;
            // The responder still drives read data on this last high cycle.
            if (BusReadWrite == RW_READ) begin
              RspData  <= BusData;
              RspValid <= 1'b1;
            end
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        HOLD: begin
          if (r_count == '0) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_drive      <= 1'b0;
            BusAddress   <= '0;
            BusReadWrite <= RW_READ;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: one instance at HALF_PERIOD=4 and one at
// HALF_PERIOD=1, each with a simple read responder on its data bus.
module tb_bus_master;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  logic        reqValid, reqWrite, reqReady, rspValid, busy, busReadWrite, busClock;
  logic [15:0] reqAddress, busAddress;
  logic [7:0]  reqData, rspData;
  wire  [7:0]  busData;
  logic        respEnable, probeEnable;

  logic        reqValid1, reqWrite1, reqReady1, rspValid1, busy1, busReadWrite1, busClock1;
  logic [15:0] reqAddress1, busAddress1;
  logic [7:0]  reqData1, rspData1;
  wire  [7:0]  busData1;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  // Probe drives a marker only when the master must be off the bus; the responder
  // returns a fixed byte (HP=4) or an address-derived byte (HP=1) while BusClock is high.
  assign busData  = probeEnable ? 8'h96 : ((respEnable && busClock) ? 8'hC3 : 8'hzz);
  assign busData1 = busClock1 ? (busAddress1[7:0] ^ 8'hA0) : 8'hzz;

  bus_master #(.HALF_PERIOD(4), .FIFO_DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(reqValid), .ReqReady(reqReady),
    .ReqWrite(reqWrite), .ReqAddress(reqAddress), .ReqData(reqData),
    .RspValid(rspValid), .RspData(rspData), .Busy(busy), .BusAddress(busAddress),
    .BusData(busData), .BusReadWrite(busReadWrite), .BusClock(busClock)
  );

  bus_master #(.HALF_PERIOD(1), .FIFO_DEPTH(4)) dut1 (
    .Clock(Clock), .Reset(Reset), .ReqValid(reqValid1), .ReqReady(reqReady1),
    .ReqWrite(reqWrite1), .ReqAddress(reqAddress1), .ReqData(reqData1),
    .RspValid(rspValid1), .RspData(rspData1), .Busy(busy1), .BusAddress(busAddress1),
    .BusData(busData1), .BusReadWrite(busReadWrite1), .BusClock(busClock1)
  );

  task automatic test_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", reqReady); end
    vectors++; if (rspValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rspvalid: got %b expected 0", rspValid); end
    vectors++; if (rspData !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rspdata: got %h expected 00", rspData); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (busClock !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busclock: got %b expected 0", busClock); end
    vectors++; if (busAddress !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_busaddr: got %h expected 0000", busAddress); end
    vectors++; if (busReadWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rw: got %b expected 0", busReadWrite); end
    probeEnable = 1'b1;
    #1;
    vectors++; if (busData !== 8'h96) begin miscompares++; $display("[TB] FAIL reset_busdata_z: got %h expected 96 (probe)", busData); end
    probeEnable = 1'b0;
    Reset = 1'b0;
  endtask

  // Starts in the low half right after reset release, so the first edge must accept.
  task automatic test_write();
    logic expClk, expAct;
    reqWrite = 1'b1; reqAddress = 16'h0010; reqData = 8'h5A; reqValid = 1'b1;
    @(posedge Clock);
    for (int k = 0; k <= 14; k++) begin
      @(negedge Clock);
      if (k == 0) reqValid = 1'b0;
      expClk = (k >= 5 && k <= 8);
      expAct = (k >= 1 && k <= 12);
      vectors++; if (busClock !== expClk) begin miscompares++; $display("[TB] FAIL write_busclock k=%0d: got %b expected %b", k, busClock, expClk); end
      vectors++; if (busAddress !== (expAct ? 16'h0010 : 16'h0000)) begin miscompares++; $display("[TB] FAIL write_busaddr k=%0d: got %h expected %h", k, busAddress, expAct ? 16'h0010 : 16'h0000); end
      vectors++; if (busReadWrite !== expAct) begin miscompares++; $display("[TB] FAIL write_rw k=%0d: got %b expected %b", k, busReadWrite, expAct); end
      if (expAct) begin
        vectors++; if (busData !== 8'h5A) begin miscompares++; $display("[TB] FAIL write_busdata k=%0d: got %h expected 5a", k, busData); end
      end
      vectors++; if (rspValid !== 1'b0) begin miscompares++; $display("[TB] FAIL write_rspvalid k=%0d: got %b expected 0", k, rspValid); end
      vectors++; if (busy !== (k <= 12)) begin miscompares++; $display("[TB] FAIL write_busy k=%0d: got %b expected %b", k, busy, (k <= 12)); end
    end
  endtask

  task automatic test_read();
    logic expClk, expAct;
    respEnable = 1'b1;
    @(negedge Clock);
    reqWrite = 1'b0; reqAddress = 16'h0010; reqData = 8'hFF; reqValid = 1'b1;
    @(posedge Clock);
    for (int k = 0; k <= 14; k++) begin
      @(negedge Clock);
      if (k == 0) reqValid = 1'b0;
      expClk = (k >= 5 && k <= 8);
      expAct = (k >= 1 && k <= 12);
      vectors++; if (busClock !== expClk) begin miscompares++; $display("[TB] FAIL read_busclock k=%0d: got %b expected %b", k, busClock, expClk); end
      vectors++; if (busAddress !== (expAct ? 16'h0010 : 16'h0000)) begin miscompares++; $display("[TB] FAIL read_busaddr k=%0d: got %h expected %h", k, busAddress, expAct ? 16'h0010 : 16'h0000); end
      vectors++; if (busReadWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL read_rw k=%0d: got %b expected 0", k, busReadWrite); end
      if (expClk) begin
        vectors++; if (busData !== 8'hC3) begin miscompares++; $display("[TB] FAIL read_busdata k=%0d: got %h expected c3", k, busData); end
      end
      vectors++; if (rspValid !== (k == 9)) begin miscompares++; $display("[TB] FAIL read_rspvalid k=%0d: got %b expected %b", k, rspValid, (k == 9)); end
      vectors++; if (rspData !== ((k >= 9) ? 8'hC3 : 8'h00)) begin miscompares++; $display("[TB] FAIL read_rspdata k=%0d: got %h expected %h", k, rspData, (k >= 9) ? 8'hC3 : 8'h00); end
    end
    respEnable = 1'b0;
  endtask

  // A blocker write occupies the bus so four queued writes fill the FIFO.
  task automatic test_fifo_backpressure();
    logic [15:0] addrTab [6];
    logic [7:0]  dataTab [6];
    int idx, stall, cycles;
    logic readyNow;
    addrTab = '{16'h0200, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
    dataTab = '{8'h20, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    idx = 0; stall = 0; cycles = 0;
    @(negedge Clock);
    reqWrite = 1'b1; reqAddress = addrTab[0]; reqData = dataTab[0]; reqValid = 1'b1;
    while (idx < 6 && cycles < 40) begin
      readyNow = reqReady;
      if (!readyNow) stall++;
      if (idx == 5 && readyNow && stall > 0) begin
        vectors++; if (busAddress !== 16'h0100) begin miscompares++; $display("[TB] FAIL fifo_reopen_after_pop: busaddr %h expected 0100", busAddress); end
      end
      @(posedge Clock);
      @(negedge Clock);
      cycles++;
      if (readyNow) begin
        idx++;
        if (idx == 5) begin
          vectors++; if (reqReady !== 1'b0) begin miscompares++; $display("[TB] FAIL fifo_full_ready: got %b expected 0", reqReady); end
        end
        if (idx < 6) begin
          reqAddress = addrTab[idx]; reqData = dataTab[idx];
        end else begin
          reqValid = 1'b0;
        end
      end
    end
    reqValid = 1'b0;
    vectors++; if (idx != 6) begin miscompares++; $display("[TB] FAIL fifo_accept_timeout: accepted %0d expected 6", idx); end
    vectors++; if (stall != 10) begin miscompares++; $display("[TB] FAIL fifo_stall_cycles: got %0d expected 10", stall); end
    for (int t = 1; t < 6; t++) begin
      cycles = 0;
      while (busAddress == 16'h0000 && cycles < 30) begin @(negedge Clock); cycles++; end
      vectors++; if (busAddress !== addrTab[t]) begin miscompares++; $display("[TB] FAIL fifo_order_addr t=%0d: got %h expected %h", t, busAddress, addrTab[t]); end
      vectors++; if (busData !== dataTab[t]) begin miscompares++; $display("[TB] FAIL fifo_order_data t=%0d: got %h expected %h", t, busData, dataTab[t]); end
      while (busAddress != 16'h0000 && cycles < 60) begin @(negedge Clock); cycles++; end
    end
    cycles = 0;
    while (busy && cycles < 30) begin @(negedge Clock); cycles++; end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fifo_drain_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_transaction();
    @(negedge Clock);
    reqWrite = 1'b1; reqAddress = 16'h0300; reqData = 8'hE7; reqValid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    reqAddress = 16'h0301; reqData = 8'h7E;
    @(posedge Clock); @(negedge Clock);
    reqValid = 1'b0;
    repeat (5) begin @(posedge Clock); @(negedge Clock); end
    vectors++; if (busClock !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_pre_strobe: got %b expected 1", busClock); end
    vectors++; if (busData !== 8'hE7) begin miscompares++; $display("[TB] FAIL midreset_pre_data: got %h expected e7", busData); end
    Reset = 1'b1;
    #1;
    probeEnable = 1'b1;
    #1;
    vectors++; if (busClock !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busclock: got %b expected 0", busClock); end
    vectors++; if (busData !== 8'h96) begin miscompares++; $display("[TB] FAIL midreset_busdata_z: got %h expected 96 (probe)", busData); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_ready: got %b expected 1", reqReady); end
    vectors++; if (busAddress !== 16'h0000) begin miscompares++; $display("[TB] FAIL midreset_busaddr: got %h expected 0000", busAddress); end
    vectors++; if (rspData !== 8'h00) begin miscompares++; $display("[TB] FAIL midreset_rspdata: got %h expected 00", rspData); end
    probeEnable = 1'b0;
    @(posedge Clock); @(negedge Clock);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      vectors++; if (busy !== 1'b0 || busAddress !== 16'h0000) begin miscompares++; $display("[TB] FAIL midreset_no_replay k=%0d: busy %b addr %h expected 0 0000", k, busy, busAddress); end
    end
  endtask

  task automatic test_half_period_one();
    logic expClk, expRsp, expBusy;
    logic [15:0] expAddr;
    logic [7:0]  expData;
    @(negedge Clock);
    reqWrite1 = 1'b0; reqAddress1 = 16'h0021; reqData1 = 8'h00; reqValid1 = 1'b1;
    @(posedge Clock);
    for (int k = 0; k <= 9; k++) begin
      @(negedge Clock);
      expClk  = (k == 2 || k == 6);
      expRsp  = (k == 3 || k == 7);
      expBusy = (k <= 7);
      expAddr = (k >= 1 && k <= 3) ? 16'h0021 : ((k >= 5 && k <= 7) ? 16'h0022 : 16'h0000);
      expData = (k < 3) ? 8'h00 : ((k < 7) ? 8'h81 : 8'h82);
      vectors++; if (busClock1 !== expClk) begin miscompares++; $display("[TB] FAIL hp1_busclock k=%0d: got %b expected %b", k, busClock1, expClk); end
      vectors++; if (rspValid1 !== expRsp) begin miscompares++; $display("[TB] FAIL hp1_rspvalid k=%0d: got %b expected %b", k, rspValid1, expRsp); end
      vectors++; if (busAddress1 !== expAddr) begin miscompares++; $display("[TB] FAIL hp1_busaddr k=%0d: got %h expected %h", k, busAddress1, expAddr); end
      vectors++; if (rspData1 !== expData) begin miscompares++; $display("[TB] FAIL hp1_rspdata k=%0d: got %h expected %h", k, rspData1, expData); end
      vectors++; if (busy1 !== expBusy) begin miscompares++; $display("[TB] FAIL hp1_busy k=%0d: got %b expected %b", k, busy1, expBusy); end
      if (k == 0) reqAddress1 = 16'h0022;
      if (k == 1) reqValid1 = 1'b0;
    end
  endtask

  initial begin
    reqValid = 1'b0; reqWrite = 1'b0; reqAddress = 16'h0000; reqData = 8'h00;
    reqValid1 = 1'b0; reqWrite1 = 1'b0; reqAddress1 = 16'h0000; reqData1 = 8'h00;
    respEnable = 1'b0; probeEnable = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_fifo_backpressure();
    test_reset_mid_transaction();
    test_half_period_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
